keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 111 +++++++++++
 tb/tb_keypad_scan.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounced press/release detection
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row[3:0]   row sense lines, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low one-hot
//   key_code   {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle pulse on each accepted press
//   key_held   high while the accepted key stays pressed
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int MAXC = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int W = $clog2(MAXC);
    localparam logic [W-1:0] SCAN_LAST = W'(SCAN_DIV - 1);
    localparam logic [W-1:0] DEB_LAST = W'(DEBOUNCE_CNT - 1);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    state_t state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic [1:0] col_idx, col_idx_nx, row_idx;
    logic [3:0] rs_meta, rs, cand, cand_nx, key_code_nx;
    logic key_valid_nx;
    // one counter serves both phases: scan dwell in SCAN, stability count otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta   <= 4'hF;
            rs        <= 4'hF;
            state     <= SCAN;
            cnt       <= '0;
            col_idx   <= 2'd0;
            cand      <= 4'hF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            rs_meta   <= row;
            rs        <= rs_meta;
            state     <= state_nx;
            cnt       <= cnt_nx;
            col_idx   <= col_idx_nx;
            cand      <= cand_nx;
            key_code  <= key_code_nx;
            key_valid <= key_valid_nx;
        end
    end
    // lowest-index low row wins when several rows are pressed
    assign row_idx = !cand[0] ? 2'd0 : !cand[1] ? 2'd1 : !cand[2] ? 2'd2 : 2'd3;
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        col_idx_nx   = col_idx;
        cand_nx      = cand;
        key_code_nx  = key_code;
        key_valid_nx = 1'b0;
        case (state)
            SCAN: begin
                if (cnt != SCAN_LAST) begin
                    cnt_nx = cnt + W'(1);
                end else if (rs == 4'hF) begin
                    cnt_nx     = '0;
                    col_idx_nx = col_idx + 2'd1;
                end else begin
                    cnt_nx   = '0;
                    cand_nx  = rs;
                    state_nx = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (rs != cand) begin
                    cnt_nx     = '0;
                    col_idx_nx = col_idx + 2'd1;
                    state_nx   = SCAN;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx       = '0;
                    key_code_nx  = {row_idx, col_idx};
                    key_valid_nx = 1'b1;
                    state_nx     = HELD;
                end else begin
                    cnt_nx = cnt + W'(1);
                end
            end
            HELD: begin
                if (rs == 4'hF) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE;
                end
            end
            default: begin
                if (rs != 4'hF) begin
                    cnt_nx   = '0;
                    state_nx = HELD;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx     = '0;
                    col_idx_nx = col_idx + 2'd1;
                    state_nx   = SCAN;
                end else begin
                    cnt_nx = cnt + W'(1);
                end
            end
        endcase
    end
    assign col      = ~(4'b0001 << col_idx);
    assign key_held = (state == HELD) || (state == RELEASE);
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan with a behavioural keypad model
module tb_keypad_scan;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE_CNT = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] row, col, key_code;
    logic key_valid, key_held;
    logic pressed = 1'b0;
    logic [1:0] press_col = 2'd0;
    logic [3:0] pattern = 4'hF;
    logic [3:0] exp_q[$];
    int tests = 0;
    int failed = 0;
    int pulses = 0;
    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );
    always #5 clk = ~clk;
    // keypad model: the pressed pattern appears only while its column is driven
    assign row = (pressed && col == ~(4'b0001 << press_col)) ? pattern : 4'hF;
    always @(negedge clk) begin
        if (key_valid) begin
            pulses = pulses + 1;
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                failed = failed + 1;
                $display("FAIL unexpected_pulse: key_valid=1 key_code=%h, no press expected", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    failed = failed + 1;
                    $display("FAIL key_code: got %h expected %h", key_code, e);
                end
            end
        end
    end
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic wait_pulse(output int n);
        int p0;
        p0 = pulses;
        n = 0;
        while (pulses == p0 && n < 300) begin
            tick();
            n++;
        end
    endtask
    task automatic release_key(input string name);
        int n;
        pressed = 1'b0;
        n = 0;
        while (key_held === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (n !== 11) begin
            failed++;
            $display("FAIL %s_release_cycles: got %0d expected 11", name, n);
        end
    endtask
    task automatic press_and_check(input string name, input logic [1:0] c, input logic [3:0] p, input logic [3:0] code);
        int n;
        press_col = c;
        pattern = p;
        exp_q.push_back(code);
        pressed = 1'b1;
        wait_pulse(n);
        tests++;
        if (n >= 300) begin
            failed++;
            $display("FAIL %s_timeout: no key_valid within %0d cycles", name, n);
        end
        tests++;
        if (key_held !== 1'b1) begin
            failed++;
            $display("FAIL %s_held: got %b expected 1", name, key_held);
        end
        tick();
        tests++;
        if (key_valid !== 1'b0 || key_code !== code) begin
            failed++;
            $display("FAIL %s_after_pulse: key_valid=%b key_code=%h expected 0/%h", name, key_valid, key_code, code);
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            failed++;
            $display("FAIL reset_outputs: col=%b code=%h valid=%b held=%b expected 1110/0/0/0", col, key_code, key_valid, key_held);
        end
    endtask
    task automatic test_idle_scan();
        logic [3:0] e;
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            e = ~(4'b0001 << ((i / 4) % 4));
            tests++;
            if (col !== e) begin
                failed++;
                $display("FAIL idle_col_cycle%0d: got %b expected %b", i, col, e);
            end
        end
    endtask
    task automatic test_press_release();
        press_and_check("row2col2", 2'd2, 4'b1011, 4'hA);
        release_key("row2col2");
        tests++;
        if (col !== 4'b0111) begin
            failed++;
            $display("FAIL resume_col3: got %b expected 0111", col);
        end
    endtask
    task automatic test_bounce();
        int n;
        press_col = 2'd0;
        pattern = 4'b1101;
        for (int i = 0; i < 24; i++) begin
            pressed = ((i / 3) % 2) == 0;
            tick();
        end
        pressed = 1'b1;
        exp_q.push_back(4'h4);
        wait_pulse(n);
        tests++;
        if (n >= 300 || n < 11) begin
            failed++;
            $display("FAIL bounce_latency: got %0d cycles expected 11..299", n);
        end
        release_key("bounce");
    endtask
    task automatic test_multi_row();
        press_and_check("rows13col1", 2'd1, 4'b0101, 4'h5);
        release_key("rows13col1");
    endtask
    task automatic test_back_to_back();
        press_and_check("first_r0c3", 2'd3, 4'b1110, 4'h3);
        release_key("first_r0c3");
        press_and_check("second_r0c3", 2'd3, 4'b1110, 4'h3);
        release_key("second_r0c3");
    endtask
    task automatic test_reset_held();
        press_and_check("row3col2", 2'd2, 4'b0111, 4'hE);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: col=%b code=%h valid=%b held=%b expected 1110/0/0/0", col, key_code, key_valid, key_held);
        end
        repeat (2) tick();
        pressed = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (col !== 4'b1110 || key_held !== 1'b0) begin
            failed++;
            $display("FAIL post_reset: col=%b held=%b expected 1110/0", col, key_held);
        end
        repeat (40) tick();
    endtask
    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_bounce();
        test_multi_row();
        test_back_to_back();
        test_reset_held();
        tests++;
        if (exp_q.size() !== 0) begin
            failed++;
            $display("FAIL missing_pulses: %0d expected pulses never seen", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
